// File: rtl/exe_pkg.sv
// exe_pkg: shared encodings for the execute stage (ALU control, alu_op, funct, FSM state, control bundle).
package exe_pkg;

  // ALU control codes
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;

  // Main-decoder ALU classes
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_DFLT  = 2'b11;

  // {funct7, funct3} values
  localparam logic [9:0] FUNCT_ADD = 10'h000;
  localparam logic [9:0] FUNCT_SUB = 10'h100;
  localparam logic [9:0] FUNCT_AND = 10'h007;
  localparam logic [9:0] FUNCT_OR  = 10'h006;
  localparam logic [9:0] FUNCT_SLT = 10'h002;
  localparam logic [9:0] FUNCT_MUL = 10'h008;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MUL_RUN = 1'b1
  } exe_state_t;

  // Memory-stage control bits carried through the output register
  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_to_reg;
    logic mem_write;
  } exe_ctrl_t;

endpackage

// File: rtl/exe_alu_decode.sv
// exe_alu_decode: combinational (alu_op, funct) -> ALU control mapping.
// MUL decode exists only when EXE_MUL_EN is defined.
module exe_alu_decode
  import exe_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [9:0] funct,
  output logic [3:0] alu_ctrl_c
);

  // Map the ALU class and funct field to a control code; unknown codes fall back to ADD
  always_comb begin
    alu_ctrl_c = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_ctrl_c = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_SUB: alu_ctrl_c = ALU_SUB;
          FUNCT_AND: alu_ctrl_c = ALU_AND;
          FUNCT_OR:  alu_ctrl_c = ALU_OR;
          FUNCT_SLT: alu_ctrl_c = ALU_SLT;
`ifdef EXE_MUL_EN
          FUNCT_MUL: alu_ctrl_c = ALU_MUL;
`endif
          default:   alu_ctrl_c = ALU_ADD;
        endcase
      end
      default: alu_ctrl_c = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/exe_stage_pipe.sv
// exe_stage_pipe: registered execute stage with EX/MEM output register and valid/stall/flush.
// Define EXE_MUL_EN to build the iterative shift-add multiplier (MUL_RUN state).
module exe_stage_pipe
  import exe_pkg::*;
#(
  parameter int unsigned PC_SIZE = 10,
  parameter int unsigned DATA_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               stall_in,
  input  logic               flush,
  output logic               busy,
  input  logic [PC_SIZE-1:0] PC_out,
  input  logic [DATA_W-1:0]  data1,
  input  logic [DATA_W-1:0]  data2,
  input  logic [11:0]        immediate,
  input  logic [9:0]         funct,
  input  logic [1:0]         alu_op,
  input  logic               alu_src,
  input  logic               branch_in,
  input  logic               mem_read_in,
  input  logic               mem_to_reg_in,
  input  logic               mem_write_in,
  output logic               out_valid,
  output logic [PC_SIZE-1:0] PC_jump,
  output logic               zero,
  output logic [DATA_W-1:0]  ALU_result,
  output logic               branch_out,
  output logic               mem_read_out,
  output logic               mem_to_reg_out,
  output logic               mem_write_out
);

  localparam int unsigned EXT_W = (DATA_W > PC_SIZE) ? DATA_W : PC_SIZE;

  logic [EXT_W-1:0]   imm_ext_c;
  logic [DATA_W-1:0]  op_b_c;
  logic [DATA_W-1:0]  alu_res_c;
  logic [PC_SIZE-1:0] pc_jump_c;
  logic [3:0]         alu_ctrl_c;
  exe_ctrl_t          ctrl_in_c;
  logic               accept_c;

  // Selected source for the output register
  logic               load_c;
  logic [DATA_W-1:0]  res_sel_c;
  logic [PC_SIZE-1:0] pc_sel_c;
  exe_ctrl_t          ctrl_sel_c;

  exe_alu_decode u_alu_decode (
    .alu_op     (alu_op),
    .funct      (funct),
    .alu_ctrl_c (alu_ctrl_c)
  );

  // Sign-extend the immediate once, then slice it for operand B and the branch offset
  assign imm_ext_c = EXT_W'($signed(immediate));
  assign op_b_c    = alu_src ? imm_ext_c[DATA_W-1:0] : data2;
  assign pc_jump_c = PC_out + imm_ext_c[PC_SIZE-1:0];

  assign ctrl_in_c.branch     = branch_in;
  assign ctrl_in_c.mem_read   = mem_read_in;
  assign ctrl_in_c.mem_to_reg = mem_to_reg_in;
  assign ctrl_in_c.mem_write  = mem_write_in;

  assign accept_c = in_valid & ~busy & ~flush;

  // Single-cycle ALU; wraps modulo 2^DATA_W
  always_comb begin
    alu_res_c = data1 + op_b_c;
    case (alu_ctrl_c)
      ALU_SUB: alu_res_c = data1 - op_b_c;
      ALU_AND: alu_res_c = data1 & op_b_c;
      ALU_OR:  alu_res_c = data1 | op_b_c;
      ALU_SLT: alu_res_c = DATA_W'($signed(data1) < $signed(op_b_c));
      default: ;
    endcase
  end

`ifdef EXE_MUL_EN
  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  exe_state_t         state;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  mul_a;
  logic [DATA_W-1:0]  mul_b;
  logic [DATA_W-1:0]  mul_acc;
  logic [PC_SIZE-1:0] mul_pc;
  exe_ctrl_t          mul_ctrl;
  logic               is_mul_c;
  logic               mul_last_c;
  logic [DATA_W-1:0]  mul_sum_c;

  assign busy       = stall_in | (state == ST_MUL_RUN);
  assign is_mul_c   = (alu_ctrl_c == ALU_MUL);
  assign mul_last_c = (cnt == CNT_W'(DATA_W - 1));
  assign mul_sum_c  = mul_acc + (mul_b[0] ? mul_a : '0);

  // Output register loads from the ALU in IDLE, or from the final multiplier step
  assign load_c     = (state == ST_IDLE) ? (accept_c & ~is_mul_c)
                                         : (mul_last_c & ~stall_in & ~flush);
  assign res_sel_c  = (state == ST_IDLE) ? alu_res_c : mul_sum_c;
  assign pc_sel_c   = (state == ST_IDLE) ? pc_jump_c : mul_pc;
  assign ctrl_sel_c = (state == ST_IDLE) ? ctrl_in_c : mul_ctrl;

  // Multiplier FSM: latch on MUL accept, one shift-add step per cycle, final step waits out a stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      mul_acc  <= '0;
      mul_pc   <= '0;
      mul_ctrl <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept_c && is_mul_c) begin
            mul_a    <= data1;
            mul_b    <= op_b_c;
            mul_acc  <= '0;
            mul_pc   <= pc_jump_c;
            mul_ctrl <= ctrl_in_c;
            cnt      <= '0;
            state    <= ST_MUL_RUN;
          end
        end
        ST_MUL_RUN: begin
          if (!mul_last_c) begin
            mul_acc <= mul_sum_c;
            mul_a   <= mul_a << 1;
            mul_b   <= mul_b >> 1;
            cnt     <= cnt + CNT_W'(1);
          end else if (!stall_in) begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end
`else
  assign busy       = stall_in;
  assign load_c     = accept_c;
  assign res_sel_c  = alu_res_c;
  assign pc_sel_c   = pc_jump_c;
  assign ctrl_sel_c = ctrl_in_c;
`endif

  // EX/MEM output register: flush clears valid, stall holds, otherwise valid tracks loads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid      <= 1'b0;
      ALU_result     <= '0;
      zero           <= 1'b1;
      PC_jump        <= '0;
      branch_out     <= 1'b0;
      mem_read_out   <= 1'b0;
      mem_to_reg_out <= 1'b0;
      mem_write_out  <= 1'b0;
    end else begin
      if (load_c) begin
        ALU_result     <= res_sel_c;
        zero           <= (res_sel_c == '0);
        PC_jump        <= pc_sel_c;
        branch_out     <= ctrl_sel_c.branch;
        mem_read_out   <= ctrl_sel_c.mem_read;
        mem_to_reg_out <= ctrl_sel_c.mem_to_reg;
        mem_write_out  <= ctrl_sel_c.mem_write;
      end
      if (flush) begin
        out_valid <= 1'b0;
      end else if (load_c) begin
        out_valid <= 1'b1;
      end else if (!stall_in) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_exe_stage_pipe.sv
// tb_exe_stage_pipe: directed + randomized checks of exe_stage_pipe (DATA_W=8, PC_SIZE=10).
// Multiplier sequences are included when EXE_MUL_EN is defined.
module tb_exe_stage_pipe;

`ifdef EXE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       in_valid, stall_in, flush, busy;
  logic [9:0] PC_out, PC_jump;
  logic [7:0] data1, data2, ALU_result;
  logic [11:0] immediate;
  logic [9:0] funct;
  logic [1:0] alu_op;
  logic       alu_src;
  logic       branch_in, mem_read_in, mem_to_reg_in, mem_write_in;
  logic       out_valid, zero;
  logic       branch_out, mem_read_out, mem_to_reg_out, mem_write_out;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected contents of the output register
  logic       e_valid;
  logic [7:0] e_res;
  logic [9:0] e_pc;
  logic [3:0] e_ctrl;
  // Expected result of an in-flight multiply
  logic [7:0] p_res;
  logic [9:0] p_pc;
  logic [3:0] p_ctrl;

  exe_stage_pipe #(.PC_SIZE(10), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall_in(stall_in), .flush(flush),
    .busy(busy), .PC_out(PC_out), .data1(data1), .data2(data2), .immediate(immediate),
    .funct(funct), .alu_op(alu_op), .alu_src(alu_src), .branch_in(branch_in),
    .mem_read_in(mem_read_in), .mem_to_reg_in(mem_to_reg_in), .mem_write_in(mem_write_in),
    .out_valid(out_valid), .PC_jump(PC_jump), .zero(zero), .ALU_result(ALU_result),
    .branch_out(branch_out), .mem_read_out(mem_read_out), .mem_to_reg_out(mem_to_reg_out),
    .mem_write_out(mem_write_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference ALU from the instruction-set rules
  function automatic logic [7:0] ref_alu(input logic [1:0] op, input logic [9:0] f,
                                         input logic [7:0] a, input logic [7:0] b);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (op == 2'b01) return 8'(a - b);
    if (op == 2'b10) begin
      case (f)
        10'h100: return 8'(a - b);
        10'h007: return a & b;
        10'h006: return a | b;
        10'h002: return (sa < sb) ? 8'd1 : 8'd0;
        10'h008: return MUL_EN ? 8'(int'(a) * int'(b)) : 8'(a + b);
        default: return 8'(a + b);
      endcase
    end
    return 8'(a + b);
  endfunction

  task automatic expect_from_inputs(output logic [7:0] r, output logic [9:0] pc, output logic [3:0] c);
    logic [31:0] ext;
    logic [7:0]  b;
    ext = {{20{immediate[11]}}, immediate};
    b   = alu_src ? ext[7:0] : data2;
    r   = ref_alu(alu_op, funct, data1, b);
    pc  = 10'(32'(PC_out) + ext);
    c   = {branch_in, mem_read_in, mem_to_reg_in, mem_write_in};
  endtask

  task automatic check_all(input string tag);
    check($sformatf("%s.valid", tag), 32'(out_valid), 32'(e_valid));
    check($sformatf("%s.result", tag), 32'(ALU_result), 32'(e_res));
    check($sformatf("%s.zero", tag), 32'(zero), 32'(e_res == 8'd0));
    check($sformatf("%s.pc_jump", tag), 32'(PC_jump), 32'(e_pc));
    check($sformatf("%s.ctrl", tag), 32'({branch_out, mem_read_out, mem_to_reg_out, mem_write_out}),
          32'(e_ctrl));
  endtask

  // One clock of single-cycle traffic: update expectations from the stage rules, then compare
  task automatic cycle(input string tag);
    logic [7:0] r;
    logic [9:0] pc;
    logic [3:0] c;
    if (flush) begin
      e_valid = 1'b0;
    end else if (in_valid && !stall_in) begin
      expect_from_inputs(r, pc, c);
      e_res = r; e_pc = pc; e_ctrl = c; e_valid = 1'b1;
    end else if (!stall_in) begin
      e_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; stall_in = 1'b0; flush = 1'b0;
    PC_out = '0; data1 = '0; data2 = '0; immediate = '0; funct = '0;
    alu_op = '0; alu_src = 1'b0;
    branch_in = 1'b0; mem_read_in = 1'b0; mem_to_reg_in = 1'b0; mem_write_in = 1'b0;
  endtask

  task automatic rand_instr();
    logic [9:0] ftab [7] = '{10'h000, 10'h100, 10'h007, 10'h006, 10'h002, 10'h008, 10'h3FF};
    int unsigned k;
    k = $urandom_range(0, 7);
    funct = (k < 7) ? ftab[k] : 10'($urandom);
    alu_op = 2'($urandom);
    if (MUL_EN && alu_op == 2'b10 && funct == 10'h008) funct = 10'h000;
    data1 = 8'($urandom); data2 = 8'($urandom);
    immediate = 12'($urandom); alu_src = 1'($urandom);
    PC_out = 10'($urandom);
    {branch_in, mem_read_in, mem_to_reg_in, mem_write_in} = 4'($urandom);
  endtask

  task automatic set_mul(input logic [7:0] a, input logic [7:0] b);
    idle_inputs();
    in_valid = 1'b1; alu_op = 2'b10; funct = 10'h008; data1 = a; data2 = b;
    PC_out = 10'($urandom); immediate = 12'($urandom);
    {branch_in, mem_read_in, mem_to_reg_in, mem_write_in} = 4'($urandom);
  endtask

  // Accept a multiply: output register keeps its data, valid drops
  task automatic mul_accept(input string tag);
    expect_from_inputs(p_res, p_pc, p_ctrl);
    #1 check($sformatf("%s.busy_pre", tag), 32'(busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    e_valid = 1'b0;
    check_all($sformatf("%s.accept", tag));
  endtask

  task automatic mul_wait(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      #1 check($sformatf("%s.busy", tag), 32'(busy), 32'd1);
      check_all(tag);
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic mul_done(input string tag);
    e_res = p_res; e_pc = p_pc; e_ctrl = p_ctrl; e_valid = 1'b1;
    check_all(tag);
    #1 check($sformatf("%s.busy", tag), 32'(busy), 32'(stall_in));
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    e_valid = 1'b0; e_res = '0; e_pc = '0; e_ctrl = '0;
    p_res = '0; p_pc = '0; p_ctrl = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    check("reset.busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // SUB through the funct decode
    in_valid = 1'b1; alu_op = 2'b10; funct = 10'h100; data1 = 8'd5; data2 = 8'd7; branch_in = 1'b1;
    #1 check("sub.busy", 32'(busy), 32'd0);
    cycle("sub");
    check("sub.const", 32'(ALU_result), 32'h0FE);

    // Immediate operand and negative branch offset
    idle_inputs();
    in_valid = 1'b1; alu_src = 1'b1; immediate = 12'hFFF; PC_out = 10'd10; data1 = 8'd3; alu_op = 2'b00;
    mem_read_in = 1'b1;
    cycle("imm");
    check("imm.const_res", 32'(ALU_result), 32'd2);
    check("imm.const_pc", 32'(PC_jump), 32'd9);

    // Signed SLT across the sign boundary
    idle_inputs();
    in_valid = 1'b1; alu_op = 2'b10; funct = 10'h002; data1 = 8'h80; data2 = 8'h7F;
    cycle("slt");
    check("slt.const", 32'(ALU_result), 32'd1);

    // Stall holds the output register and blocks new work
    idle_inputs();
    in_valid = 1'b1; alu_op = 2'b00; data1 = 8'h55; data2 = 8'h11; stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("stall.busy", 32'(busy), 32'd1);
      cycle("stall");
      check("stall.const", 32'(ALU_result), 32'd1);
    end

    // Flush wins over stall and incoming work
    flush = 1'b1;
    cycle("flush");
    check("flush.const", 32'(out_valid), 32'd0);
    flush = 1'b0; stall_in = 1'b0;

`ifndef EXE_MUL_EN
    // Without the multiplier, funct 0x008 is an ADD
    idle_inputs();
    in_valid = 1'b1; alu_op = 2'b10; funct = 10'h008; data1 = 8'd13; data2 = 8'd11;
    cycle("mul_as_add");
    check("mul_as_add.const", 32'(ALU_result), 32'd24);
`endif

    // Randomized single-cycle traffic with occasional stall and flush
    for (int i = 0; i < 300; i++) begin
      rand_instr();
      in_valid = ($urandom_range(0, 3) != 0);
      stall_in = ($urandom_range(0, 7) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      #1 check("rnd.busy", 32'(busy), 32'(stall_in));
      cycle("rnd");
    end
    idle_inputs();
    cycle("rnd_drain");

`ifdef EXE_MUL_EN
    // 13 * 11 with the next instruction waiting upstream
    set_mul(8'd13, 8'd11);
    mul_accept("mul13");
    in_valid = 1'b1; alu_op = 2'b00; funct = 10'h000; data1 = 8'h40; data2 = 8'h02;
    mul_wait("mul13.run", 8);
    mul_done("mul13.done");
    check("mul13.const", 32'(ALU_result), 32'h08F);
    cycle("mul13.next");
    check("mul13.next_const", 32'(ALU_result), 32'h042);

    // Random operands, including immediate as operand B
    for (int i = 0; i < 4; i++) begin
      set_mul(8'($urandom), 8'($urandom));
      alu_src = 1'($urandom);
      mul_accept("mulr");
      mul_wait("mulr.run", 8);
      mul_done("mulr.done");
    end

    // Stall arriving mid-multiply: finishes iterating, then waits on the final count
    set_mul(8'd200, 8'd3);
    mul_accept("mulst");
    for (int i = 1; i <= 11; i++) begin
      if (i >= 3) stall_in = 1'b1;
      mul_wait("mulst.run", 1);
    end
    stall_in = 1'b0;
    mul_wait("mulst.last", 1);
    mul_done("mulst.done");
    check("mulst.const", 32'(ALU_result), 32'h058);
    stall_in = 1'b1;
    cycle("mulst.hold");
    stall_in = 1'b0;

    // Flush in the 4th cycle of a multiply discards it
    set_mul(8'd9, 8'd9);
    mul_accept("mulfl");
    mul_wait("mulfl.run", 3);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    e_valid = 1'b0;
    check_all("mulfl.flushed");
    #1 check("mulfl.busy", 32'(busy), 32'd0);
    for (int i = 0; i < 12; i++) cycle("mulfl.quiet");
`endif

    // Nonzero result in the output register ahead of the reset test
    idle_inputs();
    in_valid = 1'b1; data1 = 8'h21; data2 = 8'h12; PC_out = 10'd5; immediate = 12'd4;
    branch_in = 1'b1; mem_write_in = 1'b1;
    cycle("pre_rst");
    check("pre_rst.const", 32'(ALU_result), 32'h033);
`ifdef EXE_MUL_EN
    set_mul(8'd7, 8'd5);
    mul_accept("mulrst");
    mul_wait("mulrst.run", 2);
`endif

    // Asynchronous reset takes effect without a clock edge
    reset = 1'b1;
    #1;
    e_valid = 1'b0; e_res = '0; e_pc = '0; e_ctrl = '0;
    check_all("async_rst");
    check("async_rst.busy", 32'(busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    in_valid = 1'b1; alu_op = 2'b10; funct = 10'h007; data1 = 8'hF0; data2 = 8'h3C;
    cycle("post_rst");
    check("post_rst.const", 32'(ALU_result), 32'h030);
    idle_inputs();
    cycle("post_rst.idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
